// File: rtl/fp_add_pkg.sv
// Shared constants and helpers for the pipelined FP adder.
// Encodings, flag positions and special-value builders.
package fp_add_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;
    localparam logic [1:0] RM_RUP = 2'b11;

    localparam int FLAG_INV = 2;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_INX = 0;

    // Unsigned infinity: exponent all ones, fraction zero.
    function automatic logic [63:0] fp_inf(input int ew, input int mw);
        logic [63:0] ones;
        ones = (64'd1 << ew) - 64'd1;
        return ones << mw;
    endfunction

    // Canonical quiet NaN without sign bit.
    function automatic logic [63:0] fp_qnan(input int ew, input int mw);
        return fp_inf(ew, mw) | (64'd1 << (mw - 1));
    endfunction

    // Largest finite magnitude without sign bit.
    function automatic logic [63:0] fp_maxf(input int ew, input int mw);
        return fp_inf(ew, mw) - 64'd1;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter used by the normalise stage.
// Returns N when the input is all zeros.
module fp_lzc #(
    parameter int N  = 27,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  data_i,
    output logic [CW-1:0] cnt_o
);

    // Highest set bit wins because later iterations overwrite.
    always_comb begin
        cnt_o = CW'(N);
        for (int i = 0; i < N; i++) begin
            if (data_i[i]) cnt_o = CW'(N - 1 - i);
        end
    end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage floating-point adder with valid/ready stream.
// S1 unpack/align, S2 add/sub, S3 normalise/round/pack.
module fp_add_pipe
    import fp_add_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic [1:0]             in_rm,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic [TAG_W-1:0]       out_tag,
    output logic [2:0]             out_flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;
    localparam int EW = EXP_W + 2;
    localparam int LW = $clog2(SW + 1);

    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic signed [EW-1:0] EMAXS = EW'(EMAX);
    localparam logic [W-2:0] INF_M  = (W-1)'(fp_inf(EXP_W, MAN_W));
    localparam logic [W-2:0] NAN_M  = (W-1)'(fp_qnan(EXP_W, MAN_W));
    localparam logic [W-2:0] MAXF_M = (W-1)'(fp_maxf(EXP_W, MAN_W));

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [1:0]       rm;
        logic             sp;
        logic [W-1:0]     sp_res;
        logic [2:0]       sp_flg;
        logic             sgn;
        logic             sub;
        logic [EXP_W-1:0] exp;
        logic [SW-1:0]    ml;
        logic [SW-1:0]    ms;
    } s1_t;

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [1:0]       rm;
        logic             sp;
        logic [W-1:0]     sp_res;
        logic [2:0]       sp_flg;
        logic             sgn;
        logic [EXP_W-1:0] exp;
        logic [SW:0]      sum;
    } s2_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;

    logic             out_valid_q;
    logic [W-1:0]     out_result_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [2:0]       out_flags_q;

    logic adv;
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // ---------------- S1: unpack, specials, swap, align
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    assign {sa, ea, fa} = in_a;
    assign {sb, eb, fb} = in_b;

    logic za, zb, ia, ib, na, nb, snan, a_big;
    logic [W-2:0] ma, mb;
    assign za    = (ea == '0);
    assign zb    = (eb == '0);
    assign ia    = (ea == EMAX) && (fa == '0);
    assign ib    = (eb == EMAX) && (fb == '0);
    assign na    = (ea == EMAX) && (fa != '0);
    assign nb    = (eb == EMAX) && (fb != '0);
    assign snan  = (na && !fa[MAN_W-1]) || (nb && !fb[MAN_W-1]);
    assign ma    = za ? '0 : {ea, fa};
    assign mb    = zb ? '0 : {eb, fb};
    assign a_big = (ma >= mb);

    logic             sl, ss, zs;
    logic [EXP_W-1:0] el, es, diff;
    logic [MAN_W-1:0] fl, fs;
    logic [SW-1:0]    msr, mal;

    // Order by magnitude and right-shift the smaller operand with sticky.
    always_comb begin
        {sl, el, fl} = a_big ? {sa, ea, fa} : {sb, eb, fb};
        {ss, es, fs} = a_big ? {sb, eb, fb} : {sa, ea, fa};
        zs   = a_big ? zb : za;
        diff = el - es;
        msr  = zs ? '0 : {1'b1, fs, 3'b000};
        if (int'(diff) >= SW - 1) begin
            mal    = '0;
            mal[0] = |msr;
        end else begin
            mal    = msr >> diff;
            mal[0] = mal[0] | (|(msr & ~({SW{1'b1}} << diff)));
        end
    end

    // Build the S1 bundle, resolving NaN/inf/zero-zero up front.
    always_comb begin
        s1_d.vld    = in_valid;
        s1_d.tag    = in_tag;
        s1_d.rm     = in_rm;
        s1_d.sgn    = sl;
        s1_d.sub    = sl ^ ss;
        s1_d.exp    = el;
        s1_d.ml     = {1'b1, fl, 3'b000};
        s1_d.ms     = mal;
        s1_d.sp     = 1'b1;
        s1_d.sp_res = '0;
        s1_d.sp_flg = '0;
        if (na || nb) begin
            s1_d.sp_res           = {1'b0, NAN_M};
            s1_d.sp_flg[FLAG_INV] = snan;
        end else if (ia && ib && (sa != sb)) begin
            s1_d.sp_res           = {1'b0, NAN_M};
            s1_d.sp_flg[FLAG_INV] = 1'b1;
        end else if (ia) begin
            s1_d.sp_res = {sa, INF_M};
        end else if (ib) begin
            s1_d.sp_res = {sb, INF_M};
        end else if (za && zb) begin
            s1_d.sp_res = {(sa && sb) || ((sa ^ sb) && (in_rm == RM_RDN)),
                           {(W-1){1'b0}}};
        end else begin
            s1_d.sp = 1'b0;
        end
    end

    // ---------------- S2: signed magnitude add/sub
    always_comb begin
        s2_d.vld    = s1_q.vld;
        s2_d.tag    = s1_q.tag;
        s2_d.rm     = s1_q.rm;
        s2_d.sp     = s1_q.sp;
        s2_d.sp_res = s1_q.sp_res;
        s2_d.sp_flg = s1_q.sp_flg;
        s2_d.sgn    = s1_q.sgn;
        s2_d.exp    = s1_q.exp;
        s2_d.sum    = s1_q.sub ? ({1'b0, s1_q.ml} - {1'b0, s1_q.ms})
                               : ({1'b0, s1_q.ml} + {1'b0, s1_q.ms});
    end

    // ---------------- S3: normalise, round, pack
    logic [LW-1:0]          lz;
    logic [SW-1:0]          nrm;
    logic signed [EW-1:0]   en, er;
    logic [MAN_W+1:0]       mant;
    logic                   up, inx, to_inf;
    logic [W-1:0]           res;
    logic [2:0]             flg;

    fp_lzc #(.N(SW)) u_lzc (
        .data_i (s2_q.sum[SW-1:0]),
        .cnt_o  (lz)
    );

    // Normalise, apply the rounding mode and select special outcomes.
    always_comb begin
        if (s2_q.sum[SW]) begin
            nrm    = s2_q.sum[SW:1];
            nrm[0] = nrm[0] | s2_q.sum[0];
            en     = EW'(s2_q.exp) + EW'(1);
        end else begin
            nrm = s2_q.sum[SW-1:0] << lz;
            en  = EW'(s2_q.exp) - EW'(lz);
        end
        inx = |nrm[2:0];
        case (s2_q.rm)
            RM_RNE:  up = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = s2_q.sgn & inx;
            default: up = !s2_q.sgn & inx;
        endcase
        mant   = {1'b0, nrm[SW-1:3]} + (MAN_W+2)'(up);
        er     = en + EW'(mant[MAN_W+1]);
        to_inf = (s2_q.rm == RM_RNE)
              || ((s2_q.rm == RM_RUP) && !s2_q.sgn)
              || ((s2_q.rm == RM_RDN) && s2_q.sgn);
        res = {s2_q.sgn, er[EXP_W-1:0],
               mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0]};
        flg = {2'b00, inx};
        if (s2_q.sp) begin
            res = s2_q.sp_res;
            flg = s2_q.sp_flg;
        end else if (s2_q.sum == '0) begin
            res = {s2_q.rm == RM_RDN, {(W-1){1'b0}}};
            flg = '0;
        end else if (en <= 0) begin
            res           = {s2_q.sgn, {(W-1){1'b0}}};
            flg           = '0;
            flg[FLAG_INX] = 1'b1;
        end else if (er >= EMAXS) begin
            res           = {s2_q.sgn, to_inf ? INF_M : MAXF_M};
            flg           = '0;
            flg[FLAG_OVF] = 1'b1;
            flg[FLAG_INX] = 1'b1;
        end
    end

    // Stage registers; all stages advance together or hold together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q.vld     <= 1'b0;
            s2_q.vld     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_flags_q  <= '0;
        end else if (adv) begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            out_valid_q  <= s2_q.vld;
            out_result_q <= res;
            out_tag_q    <= s2_q.tag;
            out_flags_q  <= flg;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe: single and half precision.
// Directed vectors, stall/stream and mid-flight reset.
module tb_fp_add_pipe;
    import fp_add_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_result;
    logic [1:0]  in_rm;
    logic [3:0]  in_tag, out_tag;
    logic [2:0]  out_flags;

    fp_add_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_rm(in_rm), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .out_flags(out_flags)
    );

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_in_a, h_in_b, h_out_result;
    logic [1:0]  h_in_rm;
    logic [3:0]  h_in_tag, h_out_tag;
    logic [2:0]  h_out_flags;

    fp_add_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
        .clk(clk), .rst_n(rst_n),
        .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in_a(h_in_a), .in_b(h_in_b), .in_rm(h_in_rm), .in_tag(h_in_tag),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .out_result(h_out_result), .out_tag(h_out_tag),
        .out_flags(h_out_flags)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic [2:0]  flg;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t qh[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] tag, htag;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Single-precision monitor: pop and compare on every transfer.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious: tag %h result %h", out_tag, out_result);
            end else begin
                e = q.pop_front();
                chk("result", 64'(out_result), 64'(e.res));
                chk("tag", 64'(out_tag), 64'(e.tag));
                chk("flags", 64'(out_flags), 64'(e.flg));
                if (e.lat > 0) chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    // Held outputs must not move while stalled.
    logic [38:0] hold;
    bit stalled = 0;
    always @(negedge clk) begin
        if (rst_n && out_valid && !out_ready) begin
            if (stalled)
                chk("stable", 64'({out_result, out_tag, out_flags}), 64'(hold));
            hold = {out_result, out_tag, out_flags};
            stalled = 1;
        end else begin
            stalled = 0;
        end
    end

    // Half-precision monitor.
    always @(negedge clk) begin : mon_h
        exp_t e;
        if (rst_n && h_out_valid && h_out_ready) begin
            if (qh.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL h_spurious: tag %h result %h", h_out_tag, h_out_result);
            end else begin
                e = qh.pop_front();
                chk("h_result", 64'(h_out_result), 64'(e.res));
                chk("h_tag", 64'(h_out_tag), 64'(e.tag));
                chk("h_flags", 64'(h_out_flags), 64'(e.flg));
                if (e.lat > 0) chk("h_latency", 64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] rm, input logic [31:0] r,
                        input logic [2:0] f, input int lat);
        exp_t e;
        bit ok;
        int n;
        n = 0;
        in_a = a; in_b = b; in_rm = rm; in_tag = tag; in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            if (ok) begin
                e.res = r; e.tag = tag; e.flg = f; e.lat = lat; e.acc = cyc;
                q.push_back(e);
            end
            @(posedge clk);
            n++;
        end while (!ok && n < 200);
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: tag %h not accepted", tag);
        end
        #1;
        in_valid = 1'b0;
        tag = tag + 4'd1;
    endtask

    task automatic hsend(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] r, input int lat);
        exp_t e;
        bit ok;
        int n;
        n = 0;
        h_in_a = a; h_in_b = b; h_in_rm = RM_RNE; h_in_tag = htag;
        h_in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = h_in_ready;
            if (ok) begin
                e.res = 32'(r); e.tag = htag; e.flg = 3'b000;
                e.lat = lat; e.acc = cyc;
                qh.push_back(e);
            end
            @(posedge clk);
            n++;
        end while (!ok && n < 200);
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL h_accept_timeout: tag %h not accepted", htag);
        end
        #1;
        h_in_valid = 1'b0;
        htag = htag + 4'd1;
    endtask

    task automatic v(input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] rm, input logic [31:0] r,
                     input logic [2:0] f);
        send(a, b, rm, r, f, 3);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((q.size() != 0 || qh.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(q.size() + qh.size()), 64'd0);
    endtask

    logic [31:0] sb_in[5]  = '{32'h3F800000, 32'h40000000, 32'h40400000,
                               32'h40800000, 32'h40A00000};
    logic [31:0] sb_out[5] = '{32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000};

    initial begin
        in_valid = 0; in_a = 0; in_b = 0; in_rm = 0; in_tag = 0;
        h_in_valid = 0; h_in_a = 0; h_in_b = 0; h_in_rm = 0; h_in_tag = 0;
        out_ready = 1; h_out_ready = 1;
        tag = 0; htag = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_flags", 64'(out_flags), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_h_out_valid", 64'(h_out_valid), 64'd0);
        @(posedge clk);
        #1;

        v(32'h3F800000, 32'h40000000, RM_RNE, 32'h40400000, 3'b000);
        v(32'h40400000, 32'hC0000000, RM_RNE, 32'h3F800000, 3'b000);
        v(32'h40000000, 32'hC0000000, RM_RNE, 32'h00000000, 3'b000);
        v(32'h40000000, 32'hC0000000, RM_RDN, 32'h80000000, 3'b000);
        v(32'h00000000, 32'h80000000, RM_RDN, 32'h80000000, 3'b000);
        v(32'h00000000, 32'h80000000, RM_RTZ, 32'h00000000, 3'b000);
        v(32'h80000000, 32'h80000000, RM_RNE, 32'h80000000, 3'b000);
        v(32'h3F800000, 32'h33800000, RM_RNE, 32'h3F800000, 3'b001);
        v(32'h3F800000, 32'h33800000, RM_RUP, 32'h3F800001, 3'b001);
        v(32'h3F800000, 32'h33800000, RM_RDN, 32'h3F800000, 3'b001);
        v(32'h3F800001, 32'h33800000, RM_RNE, 32'h3F800002, 3'b001);
        v(32'h3FFFFFFF, 32'h33800000, RM_RNE, 32'h40000000, 3'b001);
        v(32'h3F800000, 32'h00800000, RM_RNE, 32'h3F800000, 3'b001);
        v(32'h3F800000, 32'h00800000, RM_RUP, 32'h3F800001, 3'b001);
        v(32'h7F7FFFFF, 32'h7F7FFFFF, RM_RNE, 32'h7F800000, 3'b011);
        v(32'h7F7FFFFF, 32'h7F7FFFFF, RM_RTZ, 32'h7F7FFFFF, 3'b011);
        v(32'h7F7FFFFF, 32'h7F7FFFFF, RM_RDN, 32'h7F7FFFFF, 3'b011);
        v(32'hFF7FFFFF, 32'hFF7FFFFF, RM_RUP, 32'hFF7FFFFF, 3'b011);
        v(32'hFF7FFFFF, 32'hFF7FFFFF, RM_RDN, 32'hFF800000, 3'b011);
        v(32'h7F800000, 32'hFF800000, RM_RNE, 32'h7FC00000, 3'b100);
        v(32'h7FC00000, 32'h40000000, RM_RNE, 32'h7FC00000, 3'b000);
        v(32'h7F800001, 32'h3F800000, RM_RNE, 32'h7FC00000, 3'b100);
        v(32'h7F800000, 32'h40000000, RM_RNE, 32'h7F800000, 3'b000);
        v(32'h40000000, 32'hFF800000, RM_RNE, 32'hFF800000, 3'b000);
        v(32'h00000001, 32'h3F800000, RM_RNE, 32'h3F800000, 3'b000);
        v(32'h00C00000, 32'h80800000, RM_RNE, 32'h00000000, 3'b001);
        drain("drain_vectors");

        @(posedge clk);
        #1;
        tag = 0;
        out_ready = 0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(32'h3F800000, sb_in[i], RM_RNE, sb_out[i], 3'b000, 0);
            end
            begin
                repeat (8) @(negedge clk);
                chk("full_in_ready", 64'(in_ready), 64'd0);
                chk("full_out_valid", 64'(out_valid), 64'd1);
                chk("full_out_tag", 64'(out_tag), 64'd0);
                @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain("drain_stream");

        @(posedge clk);
        #1;
        send(32'h3F800000, 32'h40000000, RM_RNE, 32'h40400000, 3'b000, 3);
        send(32'h40400000, 32'hC0000000, RM_RNE, 32'h3F800000, 3'b000, 3);
        rst_n = 0;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(out_valid), 64'd0);
        end

        @(posedge clk);
        #1;
        hsend(16'h3C00, 16'h4000, 16'h4200, 3);
        drain("drain_h_single");
        @(posedge clk);
        #1;
        h_out_ready = 0;
        fork
            begin
                hsend(16'h4200, 16'hC000, 16'h3C00, 0);
                hsend(16'h3C00, 16'h3C00, 16'h4000, 0);
                hsend(16'h4000, 16'h4000, 16'h4400, 0);
                hsend(16'h3C00, 16'h4000, 16'h4200, 0);
            end
            begin
                repeat (7) @(negedge clk);
                chk("h_full_in_ready", 64'(h_in_ready), 64'd0);
                @(posedge clk);
                #1 h_out_ready = 1;
            end
        join
        drain("drain_h_stream");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: run exceeded time bound");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
